// File: rtl/exec_sequencer_if.sv
// Handshake, ALU-control and bus signals between decode, exec_sequencer and the datapath.
// The sequencer connects through the slave modport; its driver uses master.
interface exec_sequencer_if;
    logic       instr_valid;
    logic [5:0] instr_opcode;
    logic       instr_ready;
    logic [5:0] alu_opcode;
    logic       alu_en;
    logic       reg_we;
    logic       reg_we16;
    logic       flag_we;
    logic       bus_req;
    logic       bus_wr;
    logic       bus_io;
    logic       bus_ack;
    logic       busy;
    logic       err_timeout;
    logic       illegal_op;

    modport slave (
        input  instr_valid, instr_opcode, bus_ack,
        output instr_ready, alu_opcode, alu_en, reg_we, reg_we16, flag_we,
               bus_req, bus_wr, bus_io, busy, err_timeout, illegal_op
    );

    modport master (
        output instr_valid, instr_opcode, bus_ack,
        input  instr_ready, alu_opcode, alu_en, reg_we, reg_we16, flag_we,
               bus_req, bus_wr, bus_io, busy, err_timeout, illegal_op
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle execute sequencer: ALU enable, DAA two-pass, req/ack bus transactions
// and writeback strobes. Every output is a flop loaded from the next-state decode.
module exec_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    exec_sequencer_if.slave   sif
);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_EXEC2, S_BUS, S_WB} state_t;
    typedef enum logic [2:0] {C_ALU8, C_ALU16, C_LIMM, C_DAA, C_MEM, C_ILL} op_class_t;

    function automatic op_class_t classify(input logic [5:0] op);
        case (op)
            6'h00, 6'h01, 6'h02, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h12, 6'h13, 6'h14, 6'h15, 6'h1A:
                classify = C_ALU8;
            6'h03, 6'h04, 6'h05, 6'h1B: classify = C_ALU16;
            6'h16:                      classify = C_LIMM;
            6'h11:                      classify = C_DAA;
            6'h30, 6'h31, 6'h32, 6'h33: classify = C_MEM;
            default:                    classify = C_ILL;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [5:0]      alu_opcode_q, alu_opcode_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            instr_ready_q, instr_ready_d;
    logic            alu_en_q, alu_en_d;
    logic            reg_we_q, reg_we_d;
    logic            reg_we16_q, reg_we16_d;
    logic            flag_we_q, flag_we_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_wr_q, bus_wr_d;
    logic            bus_io_q, bus_io_d;
    logic            busy_q, busy_d;
    logic            err_timeout_q, err_timeout_d;
    logic            illegal_op_q, illegal_op_d;

    op_class_t in_cls, cur_cls;

    always_comb begin
        in_cls        = classify(sif.instr_opcode);
        cur_cls       = classify(alu_opcode_q);
        state_d       = state_q;
        alu_opcode_d  = alu_opcode_q;
        cnt_d         = cnt_q;
        err_timeout_d = 1'b0;
        illegal_op_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sif.instr_valid && instr_ready_q) begin
                    if (in_cls == C_ILL) begin
                        illegal_op_d = 1'b1;
                    end else begin
                        alu_opcode_d = sif.instr_opcode;
                        state_d      = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cur_cls == C_DAA) begin
                    state_d = S_EXEC2;
                end else if (cur_cls == C_MEM) begin
                    state_d = S_BUS;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_EXEC2: state_d = S_WB;
            S_BUS: begin
                // An ack on the last allowed cycle takes priority over the timeout.
                if (sif.bus_ack) begin
                    state_d = alu_opcode_q[0] ? S_IDLE : S_WB;
                end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs decoded from the next state so they appear registered in that state.
        instr_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        alu_en_d      = (state_d == S_EXEC) || (state_d == S_EXEC2);
        bus_req_d     = (state_d == S_BUS);
        bus_wr_d      = (state_d == S_BUS) && alu_opcode_q[0];
        bus_io_d      = (state_d == S_BUS) && alu_opcode_q[1];
        reg_we_d      = (state_d == S_WB) &&
                        (cur_cls == C_ALU8 || cur_cls == C_DAA || cur_cls == C_MEM);
        reg_we16_d    = (state_d == S_WB) && (cur_cls == C_ALU16 || cur_cls == C_LIMM);
        flag_we_d     = (state_d == S_WB) &&
                        (cur_cls == C_ALU8 || cur_cls == C_DAA || cur_cls == C_ALU16);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            alu_opcode_q  <= '0;
            cnt_q         <= '0;
            instr_ready_q <= 1'b1;
            alu_en_q      <= 1'b0;
            reg_we_q      <= 1'b0;
            reg_we16_q    <= 1'b0;
            flag_we_q     <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_io_q      <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            illegal_op_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_opcode_q  <= alu_opcode_d;
            cnt_q         <= cnt_d;
            instr_ready_q <= instr_ready_d;
            alu_en_q      <= alu_en_d;
            reg_we_q      <= reg_we_d;
            reg_we16_q    <= reg_we16_d;
            flag_we_q     <= flag_we_d;
            bus_req_q     <= bus_req_d;
            bus_wr_q      <= bus_wr_d;
            bus_io_q      <= bus_io_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    assign sif.instr_ready = instr_ready_q;
    assign sif.alu_opcode  = alu_opcode_q;
    assign sif.alu_en      = alu_en_q;
    assign sif.reg_we      = reg_we_q;
    assign sif.reg_we16    = reg_we16_q;
    assign sif.flag_we     = flag_we_q;
    assign sif.bus_req     = bus_req_q;
    assign sif.bus_wr      = bus_wr_q;
    assign sif.bus_io      = bus_io_q;
    assign sif.busy        = busy_q;
    assign sif.err_timeout = err_timeout_q;
    assign sif.illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: per-opcode vector table with pulse counts and
// return latency, plus reset, spurious-ack and mid-bus reset sequences.
module tb_exec_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exec_sequencer_if sif ();

    exec_sequencer #(
        .TIMEOUT_CYCLES(16),
        .TO_W(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sif(sif)
    );

    always #5 clk = ~clk;

    // ack_on: BUS cycle (1-based) during which bus_ack is raised, 0 = never.
    // lat: cycles after the accepting edge until instr_ready is seen high again.
    typedef struct {
        logic [5:0] op;
        int ack_on;
        int e_alu, e_rwe, e_rwe16, e_fwe;
        int e_breq, e_wr, e_io, e_to, e_ill;
        int e_lat;
        logic [5:0] e_opc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %0d expected %0d", idx, name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n_alu = 0, n_rwe = 0, n_rwe16 = 0, n_fwe = 0, n_breq = 0;
        int n_wr = 0, n_io = 0, n_to = 0, n_ill = 0, n_busy = 0, lat = 0;
        @(negedge clk);
        check("ready_before", idx, int'(sif.instr_ready), 1);
        sif.instr_valid  = 1'b1;
        sif.instr_opcode = v.op;
        for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
            @(negedge clk);
            n_alu   += int'(sif.alu_en);
            n_rwe   += int'(sif.reg_we);
            n_rwe16 += int'(sif.reg_we16);
            n_fwe   += int'(sif.flag_we);
            n_breq  += int'(sif.bus_req);
            n_wr    += int'(sif.bus_wr);
            n_io    += int'(sif.bus_io);
            n_to    += int'(sif.err_timeout);
            n_ill   += int'(sif.illegal_op);
            n_busy  += int'(sif.busy);
            if (sif.instr_ready) lat = cyc;
            // Junk opcode offered while busy must be ignored.
            sif.instr_valid  = !sif.instr_ready;
            sif.instr_opcode = 6'h01;
            sif.bus_ack      = sif.bus_req && (v.ack_on != 0) && (n_breq == v.ack_on);
        end
        sif.instr_valid = 1'b0;
        sif.bus_ack     = 1'b0;
        check("latency", idx, lat, v.e_lat);
        check("alu_en_cycles", idx, n_alu, v.e_alu);
        check("reg_we", idx, n_rwe, v.e_rwe);
        check("reg_we16", idx, n_rwe16, v.e_rwe16);
        check("flag_we", idx, n_fwe, v.e_fwe);
        check("bus_req_cycles", idx, n_breq, v.e_breq);
        check("bus_wr_cycles", idx, n_wr, v.e_wr * v.e_breq);
        check("bus_io_cycles", idx, n_io, v.e_io * v.e_breq);
        check("err_timeout", idx, n_to, v.e_to);
        check("illegal_op", idx, n_ill, v.e_ill);
        check("busy_cycles", idx, n_busy, (v.e_lat > 0) ? v.e_lat - 1 : 0);
        check("alu_opcode", idx, int'(sif.alu_opcode), int'(v.e_opc));
    endtask

    initial begin
        //                op   ack alu rwe r16 fwe breq wr io to ill lat opc
        vecs[0]  = '{6'h00, 0, 1, 1, 0, 1, 0,  0, 0, 0, 0, 3,  6'h00};
        vecs[1]  = '{6'h16, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 3,  6'h16};
        vecs[2]  = '{6'h11, 0, 2, 1, 0, 1, 0,  0, 0, 0, 0, 4,  6'h11};
        vecs[3]  = '{6'h32, 3, 1, 1, 0, 0, 3,  0, 1, 0, 0, 6,  6'h32};
        vecs[4]  = '{6'h31, 1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 3,  6'h31};
        vecs[5]  = '{6'h30, 0, 1, 0, 0, 0, 16, 0, 0, 1, 0, 18, 6'h30};
        vecs[6]  = '{6'h30, 16, 1, 1, 0, 0, 16, 0, 0, 0, 0, 19, 6'h30};
        vecs[7]  = '{6'h3F, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1,  6'h30};
        vecs[8]  = '{6'h05, 0, 1, 0, 1, 1, 0,  0, 0, 0, 0, 3,  6'h05};
        vecs[9]  = '{6'h33, 2, 1, 0, 0, 0, 2,  1, 1, 0, 0, 4,  6'h33};
        vecs[10] = '{6'h1A, 0, 1, 1, 0, 1, 0,  0, 0, 0, 0, 3,  6'h1A};
        vecs[11] = '{6'h10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1,  6'h1A};

        sif.instr_valid  = 1'b0;
        sif.instr_opcode = 6'h00;
        sif.bus_ack      = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_alu_opcode", -1, int'(sif.alu_opcode), 0);
        check("rst_busy", -1, int'(sif.busy), 0);
        check("rst_bus_req", -1, int'(sif.bus_req), 0);
        check("rst_strobes", -1, int'({sif.alu_en, sif.reg_we, sif.reg_we16, sif.flag_we}), 0);
        check("rst_errs", -1, int'({sif.err_timeout, sif.illegal_op, sif.bus_wr, sif.bus_io}), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", -1, int'(sif.instr_ready), 1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Spurious ack while idle.
        @(negedge clk);
        sif.bus_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ack_busy", 100, int'(sif.busy), 0);
        check("idle_ack_req", 100, int'(sif.bus_req), 0);
        check("idle_ack_we", 100, int'({sif.reg_we, sif.reg_we16, sif.flag_we, sif.err_timeout}), 0);
        sif.bus_ack = 1'b0;

        // Reset in the middle of a bus transaction.
        @(negedge clk);
        sif.instr_valid  = 1'b1;
        sif.instr_opcode = 6'h30;
        @(negedge clk);
        sif.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_bus_req", 101, int'(sif.bus_req), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_bus_req", 101, int'(sif.bus_req), 0);
        check("async_busy", 101, int'(sif.busy), 0);
        check("async_alu_opcode", 101, int'(sif.alu_opcode), 0);
        check("async_ready", 101, int'(sif.instr_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 101, int'(sif.instr_ready), 1);
        check("post_rst_we", 101, int'({sif.reg_we, sif.reg_we16, sif.flag_we, sif.bus_req}), 0);
        run_vec(vecs[0], 102);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execute sequencer placed between instruction decode and the ALU control decoder / register file / external bus.
- Accepts one 6-bit opcode at a time via a valid/ready handshake.
- Drives the registered ALU opcode and enable, sequences DAA's two-pass correction, and runs the req/ack bus transaction for ld/st/in/out.
- Generates register-file and flag write enables, plus timeout and illegal-opcode error pulses.

Parameters:
- TIMEOUT_CYCLES, 16, maximum number of cycles bus_req stays high waiting for bus_ack.
- TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  opcode offered.
- instr_opcode  in  6  opcode to execute.
- instr_ready  out  1  sequencer can accept an opcode.
- alu_opcode  out  6  latched opcode, feeds the ALU control decoder.
- alu_en  out  1  ALU result valid this cycle.
- reg_we  out  1  8-bit register writeback strobe.
- reg_we16  out  1  16-bit register-pair writeback strobe.
- flag_we  out  1  flag register write strobe.
- bus_req  out  1  bus/IO transaction request.
- bus_wr  out  1  1 = write (st/out), 0 = read (ld/in).
- bus_io  out  1  1 = IO space (in/out), 0 = memory (ld/st).
- bus_ack  in  1  transaction complete.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse on bus timeout.
- illegal_op  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- All outputs are registered (Moore style).
- Reset (async, reset_n=0):
  - state=IDLE; alu_opcode=6'h00; timeout counter=0.
  - All strobes, bus_req, bus_wr, bus_io, busy, err_timeout and illegal_op are 0.
  - instr_ready=1 when reset is released.
- Reset asserted mid-operation drops bus_req immediately, with no writeback.
- Opcode classes:
  - ALU8: 00,01,02,06,07,08,09,0A,0B,0C,0D,0E,0F,12,13,14,15,1A.
  - ALU16: 03,04,05,1B,16.
  - DAA: 11.
  - MEM: 30 ld, 31 st, 32 in, 33 out.
  - All other values are illegal.
- States: IDLE, EXEC, EXEC2, BUS, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch opcode into alu_opcode.
  - Legal opcode -> EXEC.
  - Illegal opcode -> illegal_op pulses next cycle, remain IDLE, alu_opcode unchanged.
- EXEC: alu_en=1 for one cycle, then:
  - DAA -> EXEC2.
  - MEM -> BUS.
  - Otherwise -> WB.
- EXEC2: alu_en=1 for one more cycle (correction pass), then -> WB.
- BUS:
  - bus_req=1; bus_wr=1 for 31/33; bus_io=1 for 32/33. These are held stable for the whole BUS state.
  - Counter clears on entry and increments each BUS cycle with bus_ack=0.
  - bus_ack=1 -> bus_req drops next cycle. Then ld/in -> WB; st/out -> IDLE with no write strobes.
  - No ack on the TIMEOUT_CYCLES-th BUS cycle -> err_timeout pulse, -> IDLE, no writeback. bus_req is therefore high for exactly TIMEOUT_CYCLES cycles.
  - An ack on that final cycle wins over the timeout.
  - bus_ack outside BUS is ignored.
- WB: one cycle, then -> IDLE.
  - ALU8 and DAA: reg_we=1, flag_we=1.
  - ALU16 except 16: reg_we16=1, flag_we=1.
  - 16 (limm): reg_we16=1, flag_we=0.
  - ld/in: reg_we=1, flag_we=0.
- Latency, with acceptance at edge T:
  - ALU8/ALU16: alu_en during T+1, WB during T+2, ready again at T+3.
  - DAA: ready again one cycle later than ALU8.
  - MEM: BUS starts at T+2.
- instr_opcode is ignored while instr_ready=0.
- alu_opcode holds its value after returning to IDLE until the next accepted legal opcode.

Test Plan:
1. Reset release, then opcode 0x00 valid for one cycle -> alu_opcode=00, alu_en high 1 cycle, next cycle reg_we=1 and flag_we=1, instr_ready back high 3 cycles after acceptance.
2. Opcode 0x16 -> reg_we16=1 with flag_we=0 in WB. Opcode 0x11 -> alu_en high 2 consecutive cycles, then reg_we=1 and flag_we=1.
3. Opcode 0x32, bus_ack after 3 BUS cycles -> bus_req=1, bus_io=1, bus_wr=0 for 3 cycles, then reg_we=1. Opcode 0x31 with immediate ack -> bus_wr=1, bus_io=0, no write strobes, back to IDLE.
4. Opcode 0x30, bus_ack never asserted, TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, err_timeout single pulse, no reg_we. Repeat with ack on cycle 16 -> reg_we=1, no err_timeout.
5. Opcode 0x3F -> illegal_op single pulse, busy stays 0, alu_opcode unchanged. Spurious bus_ack while IDLE -> no effect.
6. reset_n driven low during BUS -> bus_req low asynchronously, all outputs at reset values, instr_ready=1 once reset_n returns high.
